charlieplex_scan_ctrl: RTL and testbench

Frame controller and scan scheduler for the charlieplexed LED matrix driver. It holds a double-buffered 144-bit LED frame written by a host over a byte-wide valid/ready port, and presents the front buffer as `led_state` to the matrix driver. It sequences row scanning with a programmable dwell time and an anti-ghosting blank interval. Host frames are committed atomically at frame boundaries, so the driver never scans a half-written frame.

---
 rtl/charlieplex_scan_ctrl.sv | 154 +++++++++++++++
 tb/tb_charlieplex_scan_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/charlieplex_scan_ctrl.sv
// Charlieplexed LED matrix frame controller and row scan scheduler.
// The host edits a 144-bit back buffer a byte at a time; a commit copies it
// to the front buffer (led_state) only at the frame wrap, so the driver never
// scans a half-written frame. Rows are scanned with a blanking gap before
// each row's dwell to suppress ghosting.

// One byte of frame storage: host-writable back byte plus its front copy.
module charlieplex_byte_lane (
  input  logic       clock,
  input  logic       aclr,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       copy,
  output logic [7:0] back,
  output logic [7:0] front
);

  // back takes host writes; front snapshots back on a committed boundary
  always_ff @(posedge clock) begin
    if (aclr) begin
      back  <= '0;
      front <= '0;
    end else begin
      if (wr_en) back  <= wr_data;
      if (copy)  front <= back;
    end
  end

endmodule

module charlieplex_scan_ctrl #(
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic         clock,
  input  logic         aclr,
  input  logic         wr_valid,
  output logic         wr_ready,
  input  logic [4:0]   wr_addr,
  input  logic [7:0]   wr_data,
  output logic         wr_err,
  input  logic         commit,
  output logic         commit_pending,
  output logic [143:0] led_state,
  output logic [3:0]   row_sel,
  output logic         row_en,
  output logic         frame_start
);

  localparam int          NUM_BYTES  = 18;
  localparam logic [15:0] DWELL_LAST = 16'(DWELL_CYCLES - 1);
  localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYCLES - 1);
  localparam logic [3:0]  ROW_LAST   = 4'd8;

  typedef enum logic {ST_BLANK, ST_DWELL} scan_state_t;

  typedef struct packed {
    logic [4:0] addr;
    logic [7:0] data;
  } wr_req_t;

  scan_state_t                       state;
  logic [15:0]                       cnt;
  wr_req_t                           wr_req;
  logic                              wr_acc;
  logic                              addr_ok;
  logic                              boundary;
  logic                              swap;
  logic                              pend_nxt;
  logic [NUM_BYTES-1:0][7:0]         back_buf;
  logic [NUM_BYTES-1:0][7:0]         front_buf;

  assign wr_req   = '{addr: wr_addr, data: wr_data};
  assign wr_acc   = wr_valid && wr_ready;
  assign addr_ok  = (wr_req.addr < 5'(NUM_BYTES));

  // Frame wrap: the last dwell cycle of the last row.
  assign boundary = (state == ST_DWELL) && (cnt == DWELL_LAST) &&
                    (row_sel == ROW_LAST);
  assign swap     = boundary && commit_pending;

  // Only the registered pending flag is looked at on the boundary; a commit
  // that shows up while pending (including on the boundary itself) is dropped.
  assign pend_nxt = commit_pending ? !boundary : commit;

  assign led_state = front_buf;

  // Per-byte storage lanes; each lane decodes its own write strobe.
  for (genvar n = 0; n < NUM_BYTES; n++) begin : g_lane
    charlieplex_byte_lane u_lane (
      .clock   (clock),
      .aclr    (aclr),
      .wr_en   (wr_acc && addr_ok && (wr_req.addr == 5'(n))),
      .wr_data (wr_req.data),
      .copy    (swap),
      .back    (back_buf[n]),
      .front   (front_buf[n])
    );
  end

  // Host handshake: pending flag, ready (mirror of !pending) and error pulse.
  always_ff @(posedge clock) begin
    if (aclr) begin
      commit_pending <= 1'b0;
      wr_ready       <= 1'b1;
      wr_err         <= 1'b0;
    end else begin
      commit_pending <= pend_nxt;
      wr_ready       <= !pend_nxt;
      wr_err         <= wr_acc && !addr_ok;
    end
  end

  // Scan FSM: BLANK then DWELL per row; row_sel advances only on BLANK entry.
  always_ff @(posedge clock) begin
    if (aclr) begin
      state       <= ST_BLANK;
      cnt         <= '0;
      row_sel     <= '0;
      row_en      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      case (state)
        ST_BLANK: begin
          if (cnt == BLANK_LAST) begin
            state  <= ST_DWELL;
            cnt    <= '0;
            row_en <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_DWELL: begin
          if (cnt == DWELL_LAST) begin
            state       <= ST_BLANK;
            cnt         <= '0;
            row_en      <= 1'b0;
            row_sel     <= (row_sel == ROW_LAST) ? 4'd0 : row_sel + 4'd1;
            frame_start <= (row_sel == ROW_LAST);
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          state  <= ST_BLANK;
          cnt    <= '0;
          row_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_charlieplex_scan_ctrl.sv
// Bench for charlieplex_scan_ctrl: directed steps plus a random phase, all
// checked every cycle against a cycle-count/array reference model.
module tb_charlieplex_scan_ctrl;

  localparam int DW      = 4;
  localparam int BL      = 2;
  localparam int ROW_P   = DW + BL;
  localparam int FRAME_P = 9 * ROW_P;

  logic         clock = 1'b0;
  logic         aclr;
  logic         wr_valid;
  logic         wr_ready;
  logic [4:0]   wr_addr;
  logic [7:0]   wr_data;
  logic         wr_err;
  logic         commit;
  logic         commit_pending;
  logic [143:0] led_state;
  logic [3:0]   row_sel;
  logic         row_en;
  logic         frame_start;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [7:0] m_back  [18];
  logic [7:0] m_front [18];
  bit         m_pend;
  bit         m_err;
  bit         m_acc;
  int         k;          // cycles since the last reset edge

  charlieplex_scan_ctrl #(.DWELL_CYCLES(DW), .BLANK_CYCLES(BL)) dut (
    .clock          (clock),
    .aclr           (aclr),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_err         (wr_err),
    .commit         (commit),
    .commit_pending (commit_pending),
    .led_state      (led_state),
    .row_sel        (row_sel),
    .row_en         (row_en),
    .frame_start    (frame_start)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  // Advance the model across one clock edge using the inputs the bench drove.
  task automatic model_edge();
    bit bnd;
    if (aclr) begin
      for (int i = 0; i < 18; i++) begin
        m_back[i]  = 8'h00;
        m_front[i] = 8'h00;
      end
      m_pend = 1'b0;
      m_err  = 1'b0;
      m_acc  = 1'b0;
      k      = 0;
    end else begin
      bnd   = ((k + 1) % FRAME_P) == 0;
      m_acc = wr_valid && !m_pend;
      m_err = m_acc && (wr_addr >= 5'd18);
      if (m_acc && wr_addr < 5'd18) m_back[wr_addr] = wr_data;
      if (bnd && m_pend)
        for (int i = 0; i < 18; i++) m_front[i] = m_back[i];
      if (m_pend) m_pend = !bnd;
      else        m_pend = commit;
      k++;
    end
  endtask

  task automatic check_all();
    logic [143:0] exp_led;
    for (int i = 0; i < 18; i++) exp_led[8*i +: 8] = m_front[i];
    chk("led_state",      led_state,      exp_led);
    chk("row_sel",        144'(row_sel),  144'((k / ROW_P) % 9));
    chk("row_en",         144'(row_en),   144'((k % ROW_P) >= BL));
    chk("frame_start",    144'(frame_start), 144'(k > 0 && (k % FRAME_P) == 0));
    chk("commit_pending", 144'(commit_pending), 144'(m_pend));
    chk("wr_ready",       144'(wr_ready), 144'(!m_pend));
    chk("wr_err",         144'(wr_err),   144'(m_err));
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Idle until the model sits at a given frame phase (bounded by one frame).
  task automatic run_to_phase(input int ph);
    for (int i = 0; i < FRAME_P + 1; i++) begin
      if ((k % FRAME_P) == ph) break;
      step();
    end
  endtask

  initial begin
    aclr     = 1'b1;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    commit   = 1'b0;
    k        = 0;
    m_pend   = 1'b0;
    m_err    = 1'b0;
    m_acc    = 1'b0;

    // reset state and scan cadence over more than a frame
    run(2);
    aclr = 1'b0;
    run(FRAME_P + 6);

    // bytes 0 and 17, then commit; hold through the swap
    wr_valid = 1'b1; wr_addr = 5'd0;  wr_data = 8'hA5; step();
    wr_addr = 5'd17; wr_data = 8'h3C; step();
    wr_valid = 1'b0; commit = 1'b1; step();
    commit = 1'b0;
    run(FRAME_P + 2);

    // write held while pending: stalls until wr_ready returns
    commit = 1'b1; step();
    commit = 1'b0;
    wr_valid = 1'b1; wr_addr = 5'd3; wr_data = 8'hFF;
    for (int i = 0; i < 2 * FRAME_P; i++) begin
      step();
      if (m_acc) break;
    end
    wr_valid = 1'b0;
    run(3);

    // out-of-range write
    wr_valid = 1'b1; wr_addr = 5'd20; wr_data = 8'h55; step();
    wr_valid = 1'b0; run(3);

    // write and commit together
    wr_valid = 1'b1; wr_addr = 5'd1; wr_data = 8'h5A; commit = 1'b1; step();
    wr_valid = 1'b0; commit = 1'b0;
    run(FRAME_P + 2);

    // commit on the boundary cycle, then a redundant commit while pending
    run_to_phase(FRAME_P - 1);
    commit = 1'b1; step();
    commit = 1'b0; run(5);
    commit = 1'b1; step();
    commit = 1'b0;
    run(FRAME_P + 2);

    // random traffic
    for (int i = 0; i < 500; i++) begin
      wr_valid = 1'($urandom_range(0, 1));
      wr_addr  = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 17))
                                             : 5'($urandom_range(0, 31));
      wr_data  = 8'($urandom);
      commit   = ($urandom_range(0, 19) == 0);
      step();
    end
    wr_valid = 1'b0;
    commit   = 1'b0;

    // pending commit lost to a reset during row 5 dwell
    wr_valid = 1'b1; wr_addr = 5'd9; wr_data = 8'hC3; step();
    wr_valid = 1'b0;
    run_to_phase(1);
    commit = 1'b1; step();
    commit = 1'b0;
    run_to_phase(5 * ROW_P + BL + 1);
    aclr = 1'b1; step();
    aclr = 1'b0;
    run(FRAME_P + 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
